// File: rtl/piezo_tune_seq.sv
// Six-note fanfare sequencer: drives note period and clear to the piezo frequency counter,
// timing each note from a duration table and inserting a silent gap between notes.
module piezo_tune_seq #(
    parameter int unsigned DUR_UNIT = 2097152,
    parameter int unsigned GAP_CYC  = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [14:0] note_per,
    output logic        clr,
    output logic        playing,
    output logic [2:0]  note_idx,
    output logic        done
);

    localparam int unsigned MaxCyc = (8 * DUR_UNIT > GAP_CYC) ? 8 * DUR_UNIT : GAP_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam logic [CntW-1:0] DurUnitC = CntW'(DUR_UNIT);
    localparam logic [CntW-1:0] GapC     = CntW'(GAP_CYC);
    localparam logic [CntW-1:0] OneC     = CntW'(1);

    typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [14:0]     note_per_q, note_per_d;
    logic            clr_q, clr_d;
    logic            playing_q, playing_d;
    logic [2:0]      note_idx_q, note_idx_d;
    logic            done_q, done_d;

    function automatic logic [14:0] note_period(input logic [2:0] idx);
        case (idx)
            3'd0:    return 15'd31888;
            3'd1:    return 15'd23889;
            3'd2:    return 15'd18961;
            3'd3:    return 15'd15944;
            3'd4:    return 15'd18961;
            default: return 15'd15944;
        endcase
    endfunction

    function automatic logic [CntW-1:0] note_cycles(input logic [2:0] idx);
        logic [CntW-1:0] units;
        case (idx)
            3'd3:    units = CntW'(6);
            3'd4:    units = CntW'(2);
            3'd5:    units = CntW'(8);
            default: units = CntW'(4);
        endcase
        return units * DurUnitC;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        note_per_d = note_per_q;
        clr_d      = clr_q;
        playing_d  = playing_q;
        note_idx_d = note_idx_q;
        done_d     = 1'b0;

        // Abort silences from any state; note_idx keeps the last note played.
        if (abort) begin
            state_d    = StIdle;
            cnt_d      = '0;
            note_per_d = '0;
            clr_d      = 1'b1;
            playing_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StNote;
                        cnt_d      = note_cycles(3'd0);
                        note_per_d = note_period(3'd0);
                        clr_d      = 1'b0;
                        playing_d  = 1'b1;
                        note_idx_d = 3'd0;
                    end
                end
                StNote: begin
                    if (cnt_q == OneC) begin
                        clr_d = 1'b1;
                        if (note_idx_q < 3'd5) begin
                            state_d = StGap;
                            cnt_d   = GapC;
                        end else begin
                            state_d    = StIdle;
                            cnt_d      = '0;
                            note_per_d = '0;
                            playing_d  = 1'b0;
                            done_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - OneC;
                    end
                end
                StGap: begin
                    if (cnt_q == OneC) begin
                        state_d    = StNote;
                        note_idx_d = note_idx_q + 3'd1;
                        cnt_d      = note_cycles(note_idx_q + 3'd1);
                        note_per_d = note_period(note_idx_q + 3'd1);
                        clr_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q - OneC;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    note_per_d = '0;
                    clr_d      = 1'b1;
                    playing_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            note_per_q <= '0;
            clr_q      <= 1'b1;
            playing_q  <= 1'b0;
            note_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            note_per_q <= note_per_d;
            clr_q      <= clr_d;
            playing_q  <= playing_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
        end
    end

    assign note_per = note_per_q;
    assign clr      = clr_q;
    assign playing  = playing_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Bench for piezo_tune_seq: a note-schedule scoreboard predicts every output cycle by cycle
// across full tunes, ignored restarts, abort, start-with-abort, restart on done and mid-tune reset.
module tb_piezo_tune_seq;

    localparam int unsigned DurUnit = 16;
    localparam int unsigned GapCyc  = 4;
    localparam int          NumCyc  = 1320;

    typedef struct packed {
        logic [14:0] per;
        logic        clr;
        logic        playing;
        logic [2:0]  idx;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [14:0] note_per;
    logic        clr;
    logic        playing;
    logic [2:0]  note_idx;
    logic        done;
    logic [20:0] dut_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        plan_q[$];
    exp_t        cur;
    exp_t        nxt;
    int          done_cycles[$];
    int          per_tab[6]  = '{31888, 23889, 18961, 15944, 18961, 15944};
    int          unit_tab[6] = '{4, 4, 4, 6, 2, 8};

    piezo_tune_seq #(
        .DUR_UNIT (DurUnit),
        .GAP_CYC  (GapCyc)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .note_per (note_per),
        .clr      (clr),
        .playing  (playing),
        .note_idx (note_idx),
        .done     (done)
    );

    assign dut_out = {note_per, clr, playing, note_idx, done};

    always #5 clk = ~clk;

    function automatic exp_t mk(input int per, input logic c, input logic p, input int idx,
                                input logic d);
        exp_t e;
        e.per     = 15'(per);
        e.clr     = c;
        e.playing = p;
        e.idx     = 3'(idx);
        e.done    = d;
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected output stream of one full tune, starting with its first NOTE cycle.
    task automatic push_tune();
        for (int i = 0; i < 6; i++) begin
            repeat (unit_tab[i] * DurUnit) plan_q.push_back(mk(per_tab[i], 1'b0, 1'b1, i, 1'b0));
            if (i < 5) begin
                repeat (GapCyc) plan_q.push_back(mk(per_tab[i], 1'b1, 1'b1, i, 1'b0));
            end
        end
        plan_q.push_back(mk(0, 1'b1, 1'b0, 5, 1'b1));
    endtask

    initial begin
        int d0;
        int d1;
        cur = mk(0, 1'b1, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset", {11'b0, dut_out}, {11'b0, cur});
        rst = 1'b0;

        for (int t = 0; t < NumCyc; t++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("cycle %0d", t), {11'b0, dut_out}, {11'b0, cur});
            if (cur.done) done_cycles.push_back(t);

            start = (t == 0 || t == 200 || t == 469 || t == 600 || t == 650 || t == 810);
            abort = (t == 570 || t == 600);
            if (t == 800) begin
                rst = 1'b1;
                #1;
                check_eq("rst_async", {11'b0, dut_out}, {11'b0, mk(0, 1'b1, 1'b0, 0, 1'b0)});
            end
            if (t == 803) rst = 1'b0;

            if (rst) begin
                plan_q.delete();
                nxt = mk(0, 1'b1, 1'b0, 0, 1'b0);
            end else if (abort) begin
                plan_q.delete();
                nxt = mk(0, 1'b1, 1'b0, int'(cur.idx), 1'b0);
            end else if (plan_q.size() > 0) begin
                nxt = plan_q.pop_front();
            end else if (start) begin
                push_tune();
                nxt = plan_q.pop_front();
            end else begin
                nxt = mk(0, 1'b1, 1'b0, int'(cur.idx), 1'b0);
            end
            cur = nxt;
        end

        d0 = (done_cycles.size() > 0) ? done_cycles[0] : -1;
        d1 = (done_cycles.size() > 1) ? done_cycles[1] : -1;
        check_eq("done_count", 32'(done_cycles.size()), 32'd2);
        check_eq("done_first", 32'(d0), 32'd469);
        check_eq("done_second", 32'(d1), 32'd1279);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
